// File: rtl/apu_event_sequencer.sv
// Timed event FIFO replayed as register-file writes on the sample strobe; host writes always win the port.
// Delay-0 event writes 3 cycles after push; ready drops when full; APU_SEQ_IRQ_EN adds the low-water irq_o.
module apu_event_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FREQ_OFFSET   = 1,
  parameter int unsigned GAIN_OFFSET   = 2,
  parameter int unsigned CTRL_OFFSET   = 0,
  parameter logic [31:0] NOTE_ON_CTRL  = 32'h0000_000F,
  parameter logic [31:0] NOTE_OFF_CTRL = 32'h0000_0005
`ifdef APU_SEQ_IRQ_EN
  ,
  parameter int unsigned LOW_WATER     = 4
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       run_i,
  input  logic                       flush_i,
  input  logic                       tick_i,
  input  logic                       event_valid_i,
  output logic                       event_ready_o,
  input  logic [15:0]                event_delay_i,
  input  logic [1:0]                 event_channel_i,
  input  logic [1:0]                 event_op_i,
  input  logic [31:0]                event_data_i,
  input  logic                       host_write_i,
  input  logic [10:0]                host_write_address_i,
  input  logic [31:0]                host_write_data_i,
  input  logic [3:0]                 host_write_strobe_i,
  output logic                       write_o,
  output logic [10:0]                write_address_o,
  output logic [31:0]                write_data_o,
  output logic [3:0]                 write_strobe_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [10:0] FREQ_OFF = 11'(FREQ_OFFSET);
  localparam logic [10:0] GAIN_OFF = 11'(GAIN_OFFSET);
  localparam logic [10:0] CTRL_OFF = 11'(CTRL_OFFSET);

  localparam logic [1:0] OP_SET_FREQ = 2'd0;
  localparam logic [1:0] OP_SET_GAIN = 2'd1;
  localparam logic [1:0] OP_NOTE_ON  = 2'd2;
  localparam logic [1:0] OP_NOTE_OFF = 2'd3;

  typedef struct packed {
    logic [15:0] delay;
    logic [1:0]  channel;
    logic [1:0]  op;
    logic [31:0] data;
  } event_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUE1 = 2'd2,
    S_ISSUE2 = 2'd3
  } state_e;

  function automatic logic [10:0] reg_addr(input logic [1:0] ch, input logic [10:0] off);
    return 11'd1024 + {6'd0, ch, 3'd0} + off;
  endfunction

  event_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  event_t          head;
  event_t          in_ev;
  logic            push, pop;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      ch_q, op_q;
  logic [31:0]     data_q;

  logic            seq_wr;
  logic [10:0]     seq_addr;
  logic [31:0]     seq_data;
  logic [3:0]      seq_strb;

  assign in_ev         = '{delay: event_delay_i, channel: event_channel_i,
                           op: event_op_i, data: event_data_i};
  assign head          = mem_q[rd_ptr_q];
  assign event_ready_o = (count_q != CW'(DEPTH));
  assign push          = event_valid_i & event_ready_o & ~flush_i;
  assign fifo_count_o  = count_q;
  assign busy_o        = (state_q != S_IDLE) | (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is not reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_ev;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    seq_wr   = 1'b0;
    seq_addr = '0;
    seq_data = '0;
    seq_strb = '0;
    case (state_q)
      S_IDLE: begin
        if (run_i && count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = head.delay;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (run_i && (cnt_q == 16'd0 || (cnt_q == 16'd1 && tick_i))) begin
          state_d = S_ISSUE1;
        end else if (run_i && tick_i) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_ISSUE1: begin
        if (run_i && !host_write_i) begin
          seq_wr   = 1'b1;
          seq_strb = 4'b1111;
          state_d  = S_IDLE;
          case (op_q)
            OP_SET_FREQ: begin
              seq_addr = reg_addr(ch_q, FREQ_OFF);
              seq_data = data_q;
            end
            OP_SET_GAIN: begin
              seq_addr = reg_addr(ch_q, GAIN_OFF);
              seq_data = {16'b0, data_q[15:0]};
              seq_strb = 4'b0011;
            end
            OP_NOTE_ON: begin
              seq_addr = reg_addr(ch_q, FREQ_OFF);
              seq_data = data_q;
              state_d  = S_ISSUE2;
            end
            default: begin
              seq_addr = reg_addr(ch_q, CTRL_OFF);
              seq_data = NOTE_OFF_CTRL;
            end
          endcase
        end
      end
      S_ISSUE2: begin
        if (run_i && !host_write_i) begin
          seq_wr   = 1'b1;
          seq_addr = reg_addr(ch_q, CTRL_OFF);
          seq_data = NOTE_ON_CTRL;
          seq_strb = 4'b1111;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush aborts whatever is in flight, including the second half of a NOTE_ON.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pop     = 1'b0;
      seq_wr  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        ch_q   <= head.channel;
        op_q   <= head.op;
        data_q <= head.data;
      end
    end
  end

  always_comb begin
    write_o         = 1'b0;
    write_address_o = '0;
    write_data_o    = '0;
    write_strobe_o  = '0;
    if (host_write_i) begin
      write_o         = 1'b1;
      write_address_o = host_write_address_i;
      write_data_o    = host_write_data_i;
      write_strobe_o  = host_write_strobe_i;
    end else if (seq_wr) begin
      write_o         = 1'b1;
      write_address_o = seq_addr;
      write_data_o    = seq_data;
      write_strobe_o  = seq_strb;
    end
  end

`ifdef APU_SEQ_IRQ_EN
  localparam logic [CW-1:0] LW = CW'(LOW_WATER);

  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (flush_i) begin
      irq_d = 1'b0;
    end else if (count_q > LW && count_d <= LW) begin
      irq_d = 1'b1;
    end else if (push && count_d > LW) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: doc/apu_event_sequencer.md
Name: apu_event_sequencer

Overview:
- Time-scheduled writer for the audio synthesis unit register file.
- CPU queues timed events: delay in sample ticks, channel, opcode and data. The block replays them as register writes on the register-file write port, aligned to the sample-rate strobe.
- Sits between the CPU bus slave and the register file and arbitrates the single write port. Host writes always win; the sequencer stalls.

Parameters:
- DEPTH, 16: event FIFO depth in entries; power of two, minimum 2.
- FREQ_OFFSET, 1: per-channel register offset of the phase-increment register.
- GAIN_OFFSET, 2: per-channel offset of the gain register.
- CTRL_OFFSET, 0: per-channel offset of the control register.
- NOTE_ON_CTRL, 32'h0000_000F: control word written by NOTE_ON.
- NOTE_OFF_CTRL, 32'h0000_0005: control word written by NOTE_OFF.
- LOW_WATER, 4: FIFO level threshold for the optional interrupt.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- run_i  in  1  1 = sequencer may count and issue; 0 = frozen
- flush_i  in  1  empty FIFO, abort current event
- tick_i  in  1  one-cycle sample-rate strobe
- event_valid_i  in  1  event push request
- event_ready_o  out  1  FIFO not full
- event_delay_i  in  16  ticks to wait after the previous event completes
- event_channel_i  in  2  target synthesiser 0..3
- event_op_i  in  2  0 = SET_FREQ, 1 = SET_GAIN, 2 = NOTE_ON, 3 = NOTE_OFF
- event_data_i  in  32  payload
- host_write_i  in  1  CPU write request
- host_write_address_i  in  11  CPU write address
- host_write_data_i  in  32  CPU write data
- host_write_strobe_i  in  4  CPU byte strobes
- write_o  out  1  to register file
- write_address_o  out  11  to register file
- write_data_o  out  32  to register file
- write_strobe_o  out  4  to register file
- busy_o  out  1  state != IDLE or FIFO not empty
- fifo_count_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- irq_o  out  1  low-water interrupt (optional feature)

Behaviour:
- Reset: all of the following are 0 or empty one cycle after rst_i.
  - FIFO empty, state IDLE, delay counter 0.
  - write_o, busy_o, fifo_count_o, irq_o = 0.
  - event_ready_o = 1.
- FIFO:
  - Push when event_valid_i & event_ready_o.
  - Head is visible the cycle after the push.
  - Push while full is ignored.
  - Simultaneous push and pop while full is not possible, because ready is low.
  - Pointers wrap modulo DEPTH.
- Write port mux is combinational.
  - host_write_i = 1: outputs mirror the host_* inputs, and the sequencer cannot issue that cycle.
  - Otherwise: outputs carry the sequencer write or all zeros.
- Address = 1024 + 8*channel + offset, 11 bits.
- FSM:
  - IDLE: if run_i & FIFO not empty: pop the head into working registers, counter <= delay, go to WAIT.
  - WAIT: if run_i & (counter == 0 or (counter == 1 & tick_i)), go to ISSUE1. Otherwise, if run_i & tick_i, decrement the counter.
    - A tick_i arriving while run_i = 0 is not counted.
  - ISSUE1: when run_i & !host_write_i, perform the write:
    - SET_FREQ: FREQ_OFFSET, data, strobe 1111; then IDLE.
    - SET_GAIN: GAIN_OFFSET, {16'b0, data[15:0]}, strobe 0011; then IDLE.
    - NOTE_ON: FREQ_OFFSET, data, strobe 1111; then ISSUE2.
    - NOTE_OFF: CTRL_OFFSET, NOTE_OFF_CTRL, strobe 1111; then IDLE.
    - If the write cannot happen, stay in ISSUE1 with write_o low.
  - ISSUE2: same stall rule; write CTRL_OFFSET, NOTE_ON_CTRL, strobe 1111; then IDLE.
- Latency:
  - Delay 0, empty FIFO, push in cycle N: pop at N+1, WAIT at N+2, write at N+3.
  - Delay D > 0: write asserted the cycle after the D-th counted tick, assuming no host stall.
- Delay is relative: counting starts at pop, and pop follows completion of the previous event.
- flush_i:
  - Highest priority after reset.
  - Empties the FIFO and forces IDLE in the same edge.
  - No sequencer write is driven in the flush cycle.
  - A flush in ISSUE2 leaves the frequency already written; this is accepted.
  - A push coincident with flush is dropped.
- Each event produces exactly one write per event (two for NOTE_ON). Writes are never duplicated or reordered.

Optional Feature:
- Macro: APU_SEQ_IRQ_EN.
- Defined:
  - irq_o is a registered level.
  - Set when fifo_count transitions from > LOW_WATER to <= LOW_WATER.
  - Cleared by a push that brings the count above LOW_WATER, by flush_i, or by reset.
- Undefined: irq_o tied to 0 and the threshold logic is removed.

Test Plan:
- Reset then push {delay 0, ch 2, SET_FREQ, 32'h0001_0000}, run_i = 1 -> exactly one write 3 cycles later: addr 1024+16+1 = 1041, data 32'h0001_0000, strobe 1111.
- Push {delay 3, ch 1, NOTE_ON, 32'h0000_2000}, tick_i every 10 cycles:
  - -> write addr 1033, data 32'h2000 the cycle after the 3rd tick;
  - -> next cycle write addr 1032, data 32'h0000_000F.
- Sequencer in ISSUE1 while host_write_i is held for 4 cycles (addr 1055) -> outputs mirror the host for 4 cycles; the sequencer write follows on cycle 5 with no loss or duplication.
- Fill 16 events -> event_ready_o = 0 and a 17th push is dropped; first pop -> ready = 1, fifo_count 15.
- Mid-WAIT with 5 queued events, flush_i pulse -> fifo_count 0, state IDLE, busy_o = 0, no further writes.
- With APU_SEQ_IRQ_EN: queue 6 events, drain -> irq_o rises when the count reaches 4; a push to 5 clears it.
